// File: rtl/wd_router_pkg.sv
// Shared types and width helpers for the W-channel router and its id queues.
package wd_router_pkg;

  localparam int DEF_NUM_SRC     = 2;
  localparam int DEF_NUM_DST     = 2;
  localparam int DEF_QUEUE_DEPTH = 4;
  localparam int LEN_W           = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [$clog2(DEF_NUM_SRC)-1:0]     src_id_t;
  typedef logic [$clog2(DEF_NUM_DST)-1:0]     dst_id_t;
  typedef logic [$clog2(DEF_QUEUE_DEPTH):0]   count_t;
  typedef logic [$clog2(DEF_QUEUE_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/wd_id_fifo.sv
// Small circular id queue with registered count; head is readable combinationally.
module wd_id_fifo
  import wd_router_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
  end

  // NOTE: storage is not reset; an entry is only read once cnt_q says it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/wd_router_nxm.sv
// NxM AXI4 W-channel crossbar routed in AW grant order; optional generated-last
// checking is enabled with the WD_LAST_CHECK_EN macro.
module wd_router_nxm
  import wd_router_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int NUM_DST     = 2,
  parameter int DATA_W      = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int SRC_ID_W    = id_width(NUM_SRC),
  parameter int DST_ID_W    = id_width(NUM_DST),
  localparam int STRB_W     = strb_width(DATA_W)
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         aw_push,
  input  logic [SRC_ID_W-1:0]          aw_src_id,
  input  logic [DST_ID_W-1:0]          aw_dst_id,
`ifdef WD_LAST_CHECK_EN
  input  logic [LEN_W-1:0]             aw_len,
`endif
  output logic                         aw_ready,
  input  logic [NUM_SRC*DATA_W-1:0]    s_wdata,
  input  logic [NUM_SRC*STRB_W-1:0]    s_wstrb,
  input  logic [NUM_SRC-1:0]           s_wlast,
  input  logic [NUM_SRC-1:0]           s_wvalid,
  output logic [NUM_SRC-1:0]           s_wready,
  output logic [NUM_DST*DATA_W-1:0]    m_wdata,
  output logic [NUM_DST*STRB_W-1:0]    m_wstrb,
  output logic [NUM_DST-1:0]           m_wlast,
  output logic [NUM_DST-1:0]           m_wvalid,
  input  logic [NUM_DST-1:0]           m_wready,
  output logic [NUM_DST-1:0]           wr_done,
`ifdef WD_LAST_CHECK_EN
  output logic [NUM_DST-1:0]           wlast_err,
`endif
  output logic [NUM_DST*SRC_ID_W-1:0]  wr_done_src
);

`ifdef WD_LAST_CHECK_EN
  localparam int DQ_W = SRC_ID_W + LEN_W;
`else
  localparam int DQ_W = SRC_ID_W;
`endif

  logic [NUM_DST-1:0]          dq_push, dq_pop, dq_empty, dq_full;
  logic [DQ_W-1:0]             dq_head [NUM_DST];
  logic [SRC_ID_W-1:0]         dq_src  [NUM_DST];
  logic [DQ_W-1:0]             dq_wdata;
  logic [NUM_SRC-1:0]          sq_push, sq_pop, sq_empty, sq_full;
  logic [DST_ID_W-1:0]         sq_head [NUM_SRC];
  logic [NUM_SRC-1:0]          bind_m  [NUM_DST];
  logic [NUM_DST-1:0]          src_last, beat_acc;
  logic [NUM_DST-1:0]          wr_done_d, wr_done_q;
  logic [NUM_DST*SRC_ID_W-1:0] wr_done_src_d, wr_done_src_q;

`ifdef WD_LAST_CHECK_EN
  logic [LEN_W-1:0]   beat_cnt_q [NUM_DST];
  logic [LEN_W-1:0]   beat_cnt_d [NUM_DST];
  logic [NUM_DST-1:0] gen_last, wlast_err_d, wlast_err_q;
  assign dq_wdata  = {aw_len, aw_src_id};
  assign wlast_err = wlast_err_q;
`else
  assign dq_wdata  = aw_src_id;
`endif

  for (genvar d = 0; d < NUM_DST; d++) begin : g_dq
    wd_id_fifo #(.WIDTH(DQ_W), .DEPTH(QUEUE_DEPTH)) u_dq (
      .clk_i  (ACLK),
      .rst_i  (ARESET),
      .push_i (dq_push[d]),
      .data_i (dq_wdata),
      .pop_i  (dq_pop[d]),
      .head_o (dq_head[d]),
      .empty_o(dq_empty[d]),
      .full_o (dq_full[d])
    );
    assign dq_src[d] = dq_head[d][SRC_ID_W-1:0];
`ifdef WD_LAST_CHECK_EN
    assign gen_last[d] = (beat_cnt_q[d] == dq_head[d][DQ_W-1 -: LEN_W]);
`endif
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_sq
    wd_id_fifo #(.WIDTH(DST_ID_W), .DEPTH(QUEUE_DEPTH)) u_sq (
      .clk_i  (ACLK),
      .rst_i  (ARESET),
      .push_i (sq_push[s]),
      .data_i (aw_dst_id),
      .pop_i  (sq_pop[s]),
      .head_o (sq_head[s]),
      .empty_o(sq_empty[s]),
      .full_o (sq_full[s])
    );
  end

  // Readiness uses registered fullness only, so a same-cycle pop never frees a slot early.
  always_comb begin
    aw_ready = 1'b1;
    for (int d = 0; d < NUM_DST; d++)
      if (aw_dst_id == DST_ID_W'(d) && dq_full[d]) aw_ready = 1'b0;
    for (int s = 0; s < NUM_SRC; s++)
      if (aw_src_id == SRC_ID_W'(s) && sq_full[s]) aw_ready = 1'b0;
    for (int d = 0; d < NUM_DST; d++)
      dq_push[d] = aw_push & aw_ready & (aw_dst_id == DST_ID_W'(d));
    for (int s = 0; s < NUM_SRC; s++)
      sq_push[s] = aw_push & aw_ready & (aw_src_id == SRC_ID_W'(s));
  end

  // A pair is bound only when each queue's oldest entry names the other side.
  always_comb begin
    for (int d = 0; d < NUM_DST; d++) begin
      bind_m[d] = '0;
      for (int s = 0; s < NUM_SRC; s++)
        bind_m[d][s] = !dq_empty[d] && (dq_src[d] == SRC_ID_W'(s)) &&
                       !sq_empty[s] && (sq_head[s] == DST_ID_W'(d));
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    m_wvalid      = '0;
    m_wdata       = '0;
    m_wstrb       = '0;
    m_wlast       = '0;
    s_wready      = '0;
    src_last      = '0;
    sq_pop        = '0;
    wr_done_src_d = '0;
    for (int d = 0; d < NUM_DST; d++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (bind_m[d][s]) begin
          m_wvalid[d]                    = s_wvalid[s];
          m_wdata[d*DATA_W +: DATA_W]    = s_wdata[s*DATA_W +: DATA_W];
          m_wstrb[d*STRB_W +: STRB_W]    = s_wstrb[s*STRB_W +: STRB_W];
          src_last[d]                    = s_wlast[s];
          s_wready[s]                    = m_wready[d];
        end
      end
    end
`ifdef WD_LAST_CHECK_EN
    for (int d = 0; d < NUM_DST; d++) m_wlast[d] = (|bind_m[d]) & gen_last[d];
`else
    m_wlast = src_last;
`endif
    beat_acc  = m_wvalid & m_wready;
    dq_pop    = beat_acc & m_wlast;
    wr_done_d = dq_pop;
    for (int d = 0; d < NUM_DST; d++) begin
      if (dq_pop[d]) wr_done_src_d[d*SRC_ID_W +: SRC_ID_W] = dq_src[d];
      for (int s = 0; s < NUM_SRC; s++)
        if (bind_m[d][s] && dq_pop[d]) sq_pop[s] = 1'b1;
    end
  end

`ifdef WD_LAST_CHECK_EN
  always_comb begin
    for (int d = 0; d < NUM_DST; d++) begin
      beat_cnt_d[d]  = beat_cnt_q[d];
      wlast_err_d[d] = beat_acc[d] & (src_last[d] != gen_last[d]);
      if (beat_acc[d]) beat_cnt_d[d] = gen_last[d] ? '0 : beat_cnt_q[d] + LEN_W'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wlast_err_q <= '0;
      for (int d = 0; d < NUM_DST; d++) beat_cnt_q[d] <= '0;
    end else begin
      wlast_err_q <= wlast_err_d;
      for (int d = 0; d < NUM_DST; d++) beat_cnt_q[d] <= beat_cnt_d[d];
    end
  end
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_done_q     <= '0;
      wr_done_src_q <= '0;
    end else begin
      wr_done_q     <= wr_done_d;
      wr_done_src_q <= wr_done_src_d;
    end
  end

  assign wr_done     = wr_done_q;
  assign wr_done_src = wr_done_src_q;

endmodule

// File: tb/tb_wd_router_nxm.sv
// Self-checking bench for wd_router_nxm: directed scenarios plus random traffic
// compared against a queue-level reference model.
module tb_wd_router_nxm;

  localparam int NS  = 2;
  localparam int ND  = 2;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int QD  = 4;
  localparam int SIW = 1;
  localparam int DIW = 1;

  logic                ACLK;
  logic                ARESET;
  logic                aw_push;
  logic [SIW-1:0]      aw_src_id;
  logic [DIW-1:0]      aw_dst_id;
  logic                aw_ready;
  logic [NS*DW-1:0]    s_wdata;
  logic [NS*SW-1:0]    s_wstrb;
  logic [NS-1:0]       s_wlast, s_wvalid, s_wready;
  logic [ND*DW-1:0]    m_wdata;
  logic [ND*SW-1:0]    m_wstrb;
  logic [ND-1:0]       m_wlast, m_wvalid, m_wready;
  logic [ND-1:0]       wr_done;
  logic [ND*SIW-1:0]   wr_done_src;
`ifdef WD_LAST_CHECK_EN
  logic [7:0]          aw_len;
  logic [ND-1:0]       wlast_err;
`endif

  wd_router_nxm #(.NUM_SRC(NS), .NUM_DST(ND), .DATA_W(DW), .QUEUE_DEPTH(QD)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .aw_push    (aw_push),
    .aw_src_id  (aw_src_id),
    .aw_dst_id  (aw_dst_id),
`ifdef WD_LAST_CHECK_EN
    .aw_len     (aw_len),
`endif
    .aw_ready   (aw_ready),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wlast    (s_wlast),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_wlast    (m_wlast),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .wr_done    (wr_done),
`ifdef WD_LAST_CHECK_EN
    .wlast_err  (wlast_err),
`endif
    .wr_done_src(wr_done_src)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // Reference model: order queues as plain lists, plus per-source burst bookkeeping.
  int            dq_m [ND][$];
  int            sq_m [NS][$];
  int            src_len [NS][$];
  int            src_beat [NS];
  int            cur_len;
  logic [ND-1:0] exp_done;
  int            exp_src [ND];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      dq_m[d].delete();
      exp_src[d] = 0;
    end
    for (int s = 0; s < NS; s++) begin
      sq_m[s].delete();
      src_len[s].delete();
      src_beat[s] = 0;
    end
    exp_done = '0;
  endtask

  // Called just after a falling edge with inputs set; checks, advances the model, moves one cycle.
  task automatic step();
    logic [ND-1:0]    e_mvalid, e_mlast, acc, pop;
    logic [ND*DW-1:0] e_mdata;
    logic [ND*SW-1:0] e_mstrb;
    logic [NS-1:0]    e_sready;
    logic             e_awready;
    int               bsrc [ND];
    #1;
    e_awready = (dq_m[aw_dst_id].size() < QD) && (sq_m[aw_src_id].size() < QD);
    e_mvalid = '0; e_mlast = '0; e_mdata = '0; e_mstrb = '0; e_sready = '0;
    acc = '0; pop = '0;
    for (int d = 0; d < ND; d++) begin
      bsrc[d] = -1;
      if (dq_m[d].size() > 0) begin
        int s;
        s = dq_m[d][0];
        if (sq_m[s].size() > 0 && sq_m[s][0] == d) bsrc[d] = s;
      end
      if (bsrc[d] >= 0) begin
        e_mvalid[d]             = s_wvalid[bsrc[d]];
        e_mlast[d]              = s_wlast[bsrc[d]];
        e_mdata[d*DW +: DW]     = s_wdata[bsrc[d]*DW +: DW];
        e_mstrb[d*SW +: SW]     = s_wstrb[bsrc[d]*SW +: SW];
        e_sready[bsrc[d]]       = m_wready[d];
        acc[d]                  = s_wvalid[bsrc[d]] & m_wready[d];
        pop[d]                  = acc[d] & s_wlast[bsrc[d]];
      end
    end
    check("aw_ready", 64'(aw_ready), 64'(e_awready));
    check("m_wvalid", 64'(m_wvalid), 64'(e_mvalid));
    check("m_wlast",  64'(m_wlast),  64'(e_mlast));
    check("m_wdata",  64'(m_wdata),  64'(e_mdata));
    check("m_wstrb",  64'(m_wstrb),  64'(e_mstrb));
    check("s_wready", 64'(s_wready), 64'(e_sready));
    check("wr_done",  64'(wr_done),  64'(exp_done));
    for (int d = 0; d < ND; d++)
      if (exp_done[d]) check("wr_done_src", 64'(wr_done_src[d*SIW +: SIW]), 64'(exp_src[d]));
    for (int d = 0; d < ND; d++) begin
      exp_done[d] = pop[d];
      if (pop[d]) exp_src[d] = bsrc[d];
      if (acc[d]) begin
        src_beat[bsrc[d]]++;
        if (pop[d]) begin
          src_beat[bsrc[d]] = 0;
          if (src_len[bsrc[d]].size() > 0) void'(src_len[bsrc[d]].pop_front());
          void'(dq_m[d].pop_front());
          void'(sq_m[bsrc[d]].pop_front());
        end
      end
    end
    if (aw_push && e_awready) begin
      dq_m[aw_dst_id].push_back(int'(aw_src_id));
      sq_m[aw_src_id].push_back(int'(aw_dst_id));
      src_len[aw_src_id].push_back(cur_len);
    end
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic idle_inputs();
    aw_push = 1'b0; s_wvalid = '0; s_wlast = '0; m_wready = '1;
  endtask

  task automatic push_aw(input int src, input int dst, input int len);
    aw_push   = 1'b1;
    aw_src_id = SIW'(src);
    aw_dst_id = DIW'(dst);
    cur_len   = len;
`ifdef WD_LAST_CHECK_EN
    aw_len    = 8'(len - 1);
`endif
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    aw_push = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    clear_model();
  endtask

  initial begin
    ARESET = 1'b1; aw_push = 1'b0; aw_src_id = '0; aw_dst_id = '0; cur_len = 1;
`ifdef WD_LAST_CHECK_EN
    aw_len = '0;
`endif
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; m_wready = '0;
    clear_model();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;

    // Reset state with every source valid: nothing may be forwarded.
    s_wvalid = '1; s_wlast = '1; m_wready = '1; s_wdata = {$urandom, $urandom};
    step();

    // Single 4-beat write src1 -> dst0.
    idle_inputs();
    push_aw(1, 0, 4);
    step();
    aw_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_wvalid = 2'b10; s_wlast = (i == 3) ? 2'b10 : 2'b00;
      s_wdata = {$urandom, $urandom}; s_wstrb = 8'($urandom);
      step();
    end
    idle_inputs();
    step();
    step();

    // Source ordering: src0 -> dst1 then src0 -> dst0.
    push_aw(0, 1, 2);
    step();
    push_aw(0, 0, 2);
    step();
    aw_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_wvalid = 2'b01; s_wlast = (i % 2 == 1) ? 2'b01 : 2'b00;
      s_wdata = {$urandom, $urandom}; s_wstrb = 8'($urandom);
      step();
    end
    idle_inputs();
    step();

    // Two disjoint paths streaming concurrently.
    push_aw(0, 0, 3);
    step();
    push_aw(1, 1, 3);
    step();
    aw_push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_wvalid = 2'b11; s_wlast = (i == 2) ? 2'b11 : 2'b00;
      s_wdata = {$urandom, $urandom}; s_wstrb = 8'($urandom);
      step();
    end
    idle_inputs();
    step();

    // Fill dst0, refused push, then pop+push at count 3 keeps the count.
    for (int i = 0; i < 4; i++) begin
      push_aw(0, 0, 1);
      step();
    end
    push_aw(1, 0, 1);
    step();
    aw_push = 1'b0; s_wvalid = 2'b01; s_wlast = 2'b01;
    step();
    push_aw(1, 0, 1); s_wvalid = 2'b01; s_wlast = 2'b01;
    step();
    s_wvalid = '0; s_wlast = '0;
    push_aw(1, 0, 1);
    step();
    push_aw(1, 0, 1);
    step();

    // Reset in the middle of a burst.
    do_reset();
    idle_inputs();
    push_aw(0, 1, 4);
    step();
    aw_push = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_wvalid = 2'b01; s_wdata = {$urandom, $urandom};
      step();
    end
    do_reset();
    s_wvalid = 2'b01; m_wready = '1;
    step();
    push_aw(0, 1, 1); s_wvalid = '0;
    step();
    aw_push = 1'b0; s_wvalid = 2'b01; s_wlast = 2'b01; s_wdata = {$urandom, $urandom};
    step();
    idle_inputs();
    step();

    // Random traffic; sources assert wlast according to their own oldest AW length.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      push_aw(int'($urandom_range(NS - 1)), int'($urandom_range(ND - 1)), int'($urandom_range(4, 1)));
      aw_push = ($urandom_range(2) == 0);
      for (int s = 0; s < NS; s++) begin
        s_wvalid[s] = ($urandom_range(3) != 0);
        s_wlast[s]  = (src_len[s].size() > 0) && (src_beat[s] == src_len[s][0] - 1);
      end
      m_wready = ND'($urandom);
      s_wdata  = {$urandom, $urandom};
      s_wstrb  = NS*SW'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
